hack_cpu_mc: RTL
================

# hack_cpu_mc

Multi-cycle Hack-ISA CPU core with parametrised data width and a stallable, handshaked data-memory port. It replaces the single-cycle core, which assumes zero-wait memory. Read-modify-write instructions (e.g. `M=M+1`) are split into sequenced read and write transactions. Instruction memory stays combinational and is indexed by `pc_o`.

## Interface
- `DATA_W`, 16: datapath width of the A, D and ALU paths; must be ≥16.
- `ADDR_W`, 15: data-memory address width; `dmem_addr_o = A[ADDR_W-1:0]`.
- `PC_W`, 15: program-counter width; jump target is `A[PC_W-1:0]`.
- `RESET_PC`, 0: PC value after reset.

Ports (clock and reset first):
- `clk_i` in 1: the single clock; all state updates on the rising edge.
- `reset_i` in 1: reset, synchronous and active-high.
- `inst_i` in 16: instruction at `pc_o`; must be valid combinationally while the core is in EXEC.
- `data_i` in DATA_W: data-memory read data; sampled only in the cycle `dmem_ack_i=1` during a read.
- `dmem_ack_i` in 1: completes the outstanding data-memory request.
- `dmem_req_o` out 1: data-memory request is outstanding.
- `dmem_we_o` out 1: 1 = write request, 0 = read request; valid while `dmem_req_o=1`.
- `dmem_addr_o` out ADDR_W: request address.
- `data_o` out DATA_W: write data; valid while `dmem_req_o & dmem_we_o`.
- `pc_o` out PC_W: current program counter.
- `retire_o` out 1: one-cycle pulse when an instruction commits.

## Operation
- Decode uses the Hack field layout:
  - `inst[15]`: 0 = A-instruction, 1 = C-instruction.
  - `a = inst[12]`; comp = `inst[11:6]` (zx, nx, zy, ny, f, no).
  - dest = `inst[5:3]` (A, D, M); jump = `inst[2:0]` (lt, eq, gt).
- A-instruction: A ← zero-extended `inst[14:0]`. Commits in EXEC.
- C-instruction ALU inputs: x = D; y = (a ? M : A).
- C-instruction classification:
  - `rd = a`.
  - `wr = dest[0]` (the M destination bit, `inst[3]`).
- FSM states: EXEC, RD, WR.
  - EXEC, A-instruction or C-instruction with `!rd & !wr`: commit this cycle, stay in EXEC.
  - EXEC, `rd`: go to RD. Assert read request to A.
  - EXEC, `!rd & wr`: go to WR. Assert write request with `data_o` = ALU(D, A).
  - RD, `ack=0`: hold the request and stay in RD.
  - RD, `ack=1` and `wr`: capture `data_i` into an M latch, go to WR.
  - RD, `ack=1` and `!wr`: commit, using `data_i` as M, go to EXEC.
  - WR, `ack=0`: hold the request and stay in WR.
  - WR, `ack=1`: commit, go to EXEC. `data_o` is computed from the latched M when `rd`, else from A.
- Commit, applied together in one edge:
  - A ← ALU when dest[2]; D ← ALU when dest[1].
  - PC ← `A_old[PC_W-1:0]` if jump taken, else PC+1, wrapping at 2^PC_W.
  - `retire_o` = 1.
- Jump-taken condition: `(j[2]&ng) | (j[1]&zr) | (j[0]&!ng&!zr)`. `ng` = ALU MSB (bit DATA_W-1); `zr` = ALU result equal to zero.
- Write-address hazard: the address used is A before commit, including for `AM=...`.
- A, D, PC and the M latch never change outside commit. `pc_o` is therefore stable through wait states.

## Timing
- Reset values, forced when `reset_i=1` at an edge:
  - A = 0, D = 0, PC = RESET_PC, state = EXEC.
  - `dmem_req_o` = 0, `retire_o` = 0, `data_o` = 0.
- Reset mid-transaction abandons the request; `dmem_req_o` drops the cycle after the reset edge.
- Latency with ack on the first request cycle (zero wait):
  - A-instruction and register-only C-instruction: 1 cycle.
  - M read or M write: 2 cycles.
  - Read-modify-write: 3 cycles.
- Each wait cycle (`ack=0`) adds 1 cycle. There is no timeout.
- `dmem_req_o`, `dmem_we_o`, `dmem_addr_o` and `data_o` are registered and held constant until ack.
- `dmem_req_o` deasserts for at least one cycle between consecutive instructions.
- RD→WR is back-to-back: the write request is asserted the cycle after the read ack.
- `dmem_ack_i` while `dmem_req_o=0` is ignored.

## Configuration
- `HACK_CPU_PERF_CNT_EN` defined:
  - Adds `retired_cnt_o` (out, 32): increments on each `retire_o`.
  - Adds `stall_cnt_o` (out, 32): increments each cycle `dmem_req_o & !dmem_ack_i`.
  - Both counters wrap modulo 2^32 and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package `hack_pkg`:
  - FSM state enum (EXEC, RD, WR).
  - Instruction field bit positions and the dest/jump bit constants.
- One sub-module, `hack_alu_w`: combinational Hack ALU parametrised by `DATA_W`, with outputs out, zr, ng.
- A, D and PC are plain registers in the top level.

## Test plan
- Reset, then `@5`, `D=A`, `@7`, `D=D+A`, all at zero wait → D=12, PC=4, exactly four `retire_o` pulses.
- `@100`, `M=D` with D=3, ack after 3 wait cycles → write at address 100 with data 3; `pc_o` held for 4 cycles; `stall_cnt_o` = 3.
- `@100`, `M=M+1` with memory returning 41 → read request at address 100, then write of 42 at address 100, on consecutive request phases; 3 cycles total at zero wait.
- `D=-1` then `@20`, `D;JLT` → PC=20. `D;JGT` with D=0 → PC+1. `0;JMP` → PC=A.
- `DATA_W=32`: `@32767`, `D=A`, `D=D+1`, `D=D+A` → D=65535. `@0`, `D;JGT` with D=0x80000000 → not taken (ng=1).
- Assert `reset_i` in RD with ack withheld → next cycle `dmem_req_o`=0 and PC=RESET_PC; PC wraps to 0 after the instruction at 2^PC_W−1 when not jumping.

Source files
------------

// File: rtl/hack_pkg.sv
// Shared definitions for the multi-cycle Hack CPU: FSM states, instruction
// field positions, ALU control bit positions and the jump-condition helper.
// No ports; imported by hack_alu_w and hack_cpu_mc.
package hack_pkg;

    typedef enum logic [1:0] {
        ST_EXEC = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_e;

    localparam int unsigned INST_W    = 16;
    localparam int unsigned IMM_W     = 15;
    localparam int unsigned BIT_CINST = 15;
    localparam int unsigned BIT_A     = 12;
    localparam int unsigned COMP_LSB  = 6;
    localparam int unsigned COMP_W    = 6;
    localparam int unsigned JUMP_LSB  = 0;
    localparam int unsigned JUMP_W    = 3;

    // Destination bits, absolute positions in the instruction word.
    localparam int unsigned DEST_A = 5;
    localparam int unsigned DEST_D = 4;
    localparam int unsigned DEST_M = 3;

    // Positions inside the 3-bit jump field.
    localparam int unsigned JMP_LT = 2;
    localparam int unsigned JMP_EQ = 1;
    localparam int unsigned JMP_GT = 0;

    // Positions inside the 6-bit comp field.
    localparam int unsigned CMP_ZX = 5;
    localparam int unsigned CMP_NX = 4;
    localparam int unsigned CMP_ZY = 3;
    localparam int unsigned CMP_NY = 2;
    localparam int unsigned CMP_F  = 1;
    localparam int unsigned CMP_NO = 0;

    function automatic logic jump_taken(input logic [JUMP_W-1:0] j,
                                        input logic ng,
                                        input logic zr);
        return (j[JMP_LT] & ng) | (j[JMP_EQ] & zr) | (j[JMP_GT] & ~ng & ~zr);
    endfunction

endpackage

// File: rtl/hack_alu_w.sv
// Combinational Hack ALU, DATA_W bits wide.
// Ports: x_i, y_i operands; comp_i = {zx, nx, zy, ny, f, no};
//        out = result, zr = result is zero, ng = result MSB.
module hack_alu_w
    import hack_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic [DATA_W-1:0] x_i,
    input  logic [DATA_W-1:0] y_i,
    input  logic [COMP_W-1:0] comp_i,
    output logic [DATA_W-1:0] out,
    output logic              zr,
    output logic              ng
);

    logic [DATA_W-1:0] xz, xn, yz, yn, fr;

    always_comb begin
        xz  = comp_i[CMP_ZX] ? '0 : x_i;
        xn  = comp_i[CMP_NX] ? ~xz : xz;
        yz  = comp_i[CMP_ZY] ? '0 : y_i;
        yn  = comp_i[CMP_NY] ? ~yz : yz;
        fr  = comp_i[CMP_F] ? (xn + yn) : (xn & yn);
        out = comp_i[CMP_NO] ? ~fr : fr;
    end

    assign zr = (out == '0);
    assign ng = out[DATA_W-1];

endmodule

// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU with a handshaked, stallable data-memory port.
// Instruction memory is combinational (inst_i at pc_o, valid in EXEC).
// Ports: clk_i, reset_i (sync, active-high); inst_i; data_i / dmem_ack_i
//        memory response; dmem_req_o / dmem_we_o / dmem_addr_o / data_o
//        memory request; pc_o program counter; retire_o commit pulse.
// Optional: HACK_CPU_PERF_CNT_EN adds retired_cnt_o and stall_cnt_o.
module hack_cpu_mc
    import hack_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 15,
    parameter int unsigned PC_W     = 15,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [INST_W-1:0] inst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              dmem_ack_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] data_o,
    output logic [PC_W-1:0]   pc_o,
    output logic              retire_o
`ifdef HACK_CPU_PERF_CNT_EN
    ,
    output logic [31:0]       retired_cnt_o,
    output logic [31:0]       stall_cnt_o
`endif
);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   areg_q, areg_d;
    logic [DATA_W-1:0]   dreg_q, dreg_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [DATA_W-1:0]   m_q, m_d;
    logic [INST_W-1:0]   ir_q, ir_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                retire_q, retire_d;

    logic [INST_W-1:0]   cur_inst;
    logic                is_c, rd, wr, commit, taken;
    logic [DATA_W-1:0]   alu_y, alu_out;
    logic                alu_zr, alu_ng;

    // Instruction in flight: live fetch in EXEC, latched copy while waiting on memory.
    always_comb begin
        cur_inst = (state_q == ST_EXEC) ? inst_i : ir_q;
        is_c     = cur_inst[BIT_CINST];
        rd       = is_c & cur_inst[BIT_A];
        wr       = is_c & cur_inst[DEST_M];
        // RD uses the returning data as M; WR replays M from the latch for RMW.
        case (state_q)
            ST_RD:   alu_y = data_i;
            ST_WR:   alu_y = rd ? m_q : areg_q;
            default: alu_y = areg_q;
        endcase
    end

    hack_alu_w #(.DATA_W(DATA_W)) u_alu (
        .x_i    (dreg_q),
        .y_i    (alu_y),
        .comp_i (cur_inst[COMP_LSB +: COMP_W]),
        .out    (alu_out),
        .zr     (alu_zr),
        .ng     (alu_ng)
    );

    assign taken = jump_taken(cur_inst[JUMP_LSB +: JUMP_W], alu_ng, alu_zr);

    // Next-state and commit logic.
    always_comb begin
        state_d  = state_q;
        areg_d   = areg_q;
        dreg_d   = dreg_q;
        pc_d     = pc_q;
        m_d      = m_q;
        ir_d     = ir_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        retire_d = 1'b0;
        commit   = 1'b0;

        case (state_q)
            ST_EXEC: begin
                if (!rd && !wr) begin
                    commit = 1'b1;
                end else begin
                    ir_d   = inst_i;
                    req_d  = 1'b1;
                    addr_d = areg_q[ADDR_W-1:0];
                    if (rd) begin
                        we_d    = 1'b0;
                        state_d = ST_RD;
                    end else begin
                        we_d    = 1'b1;
                        wdata_d = alu_out;
                        state_d = ST_WR;
                    end
                end
            end
            ST_RD: begin
                if (dmem_ack_i) begin
                    if (wr) begin
                        // Back-to-back write to the same address.
                        m_d     = data_i;
                        we_d    = 1'b1;
                        wdata_d = alu_out;
                        state_d = ST_WR;
                    end else begin
                        commit = 1'b1;
                    end
                end
            end
            ST_WR: begin
                if (dmem_ack_i) begin
                    commit = 1'b1;
                end
            end
            default: begin
                state_d = ST_EXEC;
                req_d   = 1'b0;
            end
        endcase

        if (commit) begin
            state_d  = ST_EXEC;
            req_d    = 1'b0;
            retire_d = 1'b1;
            if (!is_c) begin
                areg_d = DATA_W'(cur_inst[IMM_W-1:0]);
                pc_d   = pc_q + PC_W'(1);
            end else begin
                if (cur_inst[DEST_A]) areg_d = alu_out;
                if (cur_inst[DEST_D]) dreg_d = alu_out;
                // Jump target is A before this commit, even for A=... ;JMP.
                pc_d = taken ? areg_q[PC_W-1:0] : pc_q + PC_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= ST_EXEC;
            areg_q   <= '0;
            dreg_q   <= '0;
            pc_q     <= PC_W'(RESET_PC);
            m_q      <= '0;
            ir_q     <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            retire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            areg_q   <= areg_d;
            dreg_q   <= dreg_d;
            pc_q     <= pc_d;
            m_q      <= m_d;
            ir_q     <= ir_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            retire_q <= retire_d;
        end
    end

    assign dmem_req_o  = req_q;
    assign dmem_we_o   = we_q;
    assign dmem_addr_o = addr_q;
    assign data_o      = wdata_q;
    assign pc_o        = pc_q;
    assign retire_o    = retire_q;

`ifdef HACK_CPU_PERF_CNT_EN
    logic [31:0] retired_cnt_q, retired_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Retired count moves on the commit edge, together with retire_o.
    always_comb begin
        retired_cnt_d = retired_cnt_q + (commit ? 32'd1 : 32'd0);
        stall_cnt_d   = stall_cnt_q + ((req_q && !dmem_ack_i) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            retired_cnt_q <= '0;
            stall_cnt_q   <= '0;
        end else begin
            retired_cnt_q <= retired_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign retired_cnt_o = retired_cnt_q;
    assign stall_cnt_o   = stall_cnt_q;
`endif

endmodule
